// File: rtl/bcd_pkg.sv
// Shared constants, state type and digit width for the binary-to-BCD converter.
package bcd_pkg;

  localparam int          BCD_DIGIT_W     = 4;
  localparam logic [31:0] BCD_MAX_DECIMAL = 32'd999999;
  localparam logic [23:0] BCD_SATURATE    = 24'h999999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction step: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Build option BCD_CONVERTER_SATURATE_EN: out-of-range inputs load 999999 instead of the low digits.
module bcd_converter
  import bcd_pkg::*;
(
  input  logic        i_SYS_CLOCK,
  input  logic        i_RESET,
  input  logic [31:0] i_BUS,
  input  logic        i_START,
  output logic [23:0] o_BCD,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_VALID,
  output logic        o_OVERFLOW
);

  localparam int IN_WIDTH = 20;
  localparam int DIGITS   = 6;
  localparam int BCD_W    = BCD_DIGIT_W * DIGITS;

  state_t              state;
  logic [IN_WIDTH-1:0] shift_reg;
  logic [BCD_W:0]      scratch;
  logic [4:0]          count;
  logic                overflow_cap;
  logic [BCD_W-1:0]    adjusted;
  logic                unused_carry;

  // The top scratch bit only ever holds the 10^6 digit and is dropped at load.
  assign unused_carry = scratch[BCD_W];

  for (genvar i = 0; i < DIGITS; i++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adjusted[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign o_BUSY = (state != IDLE);

  always_ff @(posedge i_SYS_CLOCK) begin
    if (i_RESET) begin
      state        <= IDLE;
      shift_reg    <= '0;
      scratch      <= '0;
      count        <= '0;
      overflow_cap <= 1'b0;
      o_BCD        <= '0;
      o_DONE       <= 1'b0;
      o_VALID      <= 1'b0;
      o_OVERFLOW   <= 1'b0;
    end else begin
      o_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (i_START) begin
            shift_reg    <= i_BUS[IN_WIDTH-1:0];
            overflow_cap <= (i_BUS > BCD_MAX_DECIMAL);
            scratch      <= '0;
            count        <= '0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= {adjusted, shift_reg[IN_WIDTH-1]};
          shift_reg <= {shift_reg[IN_WIDTH-2:0], 1'b0};
          count     <= count + 5'd1;
          if (count == 5'(IN_WIDTH - 1)) state <= LOAD;
        end
        LOAD: begin
`ifdef BCD_CONVERTER_SATURATE_EN
          o_BCD <= overflow_cap ? BCD_SATURATE : scratch[BCD_W-1:0];
`else
          o_BCD <= scratch[BCD_W-1:0];
`endif
          o_OVERFLOW <= overflow_cap;
          o_DONE     <= 1'b1;
          o_VALID    <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: directed corner cases plus randomized conversions
// checked against an arithmetic decimal model.
module tb_bcd_converter;

  logic        i_SYS_CLOCK = 1'b0;
  logic        i_RESET     = 1'b1;
  logic [31:0] i_BUS       = '0;
  logic        i_START     = 1'b0;
  logic [23:0] o_BCD;
  logic        o_BUSY;
  logic        o_DONE;
  logic        o_VALID;
  logic        o_OVERFLOW;

  int total = 0;
  int bad   = 0;
  int done_count = 0;

  logic [24:0] exp_q[$];
  logic [23:0] prev_bcd = '0;

  bcd_converter dut (
    .i_SYS_CLOCK (i_SYS_CLOCK),
    .i_RESET     (i_RESET),
    .i_BUS       (i_BUS),
    .i_START     (i_START),
    .o_BCD       (o_BCD),
    .o_BUSY      (o_BUSY),
    .o_DONE      (o_DONE),
    .o_VALID     (o_VALID),
    .o_OVERFLOW  (o_OVERFLOW)
  );

  // ---------------- clock ----------------
  always #5 i_SYS_CLOCK = ~i_SYS_CLOCK;

  // ---------------- reference model ----------------
  // Returns {overflow, packed bcd} from plain decimal arithmetic.
  function automatic logic [24:0] model(input logic [31:0] b);
    int unsigned v;
    logic [23:0] r;
    logic        ov;
    v  = int'(b[19:0]) % 1000000;
    ov = (b > 32'd999999);
    r  = '0;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
`ifdef BCD_CONVERTER_SATURATE_EN
    if (ov) r = 24'h999999;
`endif
    return {ov, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge i_SYS_CLOCK);
    #1;
  endtask

  // Issue a request at the first cycle the block is idle; optionally record the expectation.
  task automatic convert(input logic [31:0] v, input bit push);
    int guard = 0;
    while (o_BUSY && guard < 100) begin
      step();
      guard++;
    end
    check("idle_wait_timeout", 32'(guard >= 100), 32'd0);
    i_BUS   = v;
    i_START = 1'b1;
    if (push) exp_q.push_back(model(v));
    step();
    i_START = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!o_DONE && cycles < 100);
    check("done_timeout", 32'(o_DONE), 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge i_SYS_CLOCK) begin
    if (!i_RESET) begin
      if (o_DONE) begin
        done_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [24:0] e;
          e = exp_q.pop_front();
          check("bcd", 32'(o_BCD), 32'(e[23:0]));
          check("overflow", 32'(o_OVERFLOW), 32'(e[24]));
          check("valid_on_done", 32'(o_VALID), 32'd1);
        end
      end else if (o_BCD !== prev_bcd) begin
        check("bcd_stable", 32'(o_BCD), 32'(prev_bcd));
      end
    end
    prev_bcd = o_BCD;
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int dc;
    logic [31:0] v;

    repeat (3) step();
    i_RESET = 1'b0;
    check("rst_bcd", 32'(o_BCD), 32'd0);
    check("rst_busy", 32'(o_BUSY), 32'd0);
    check("rst_done", 32'(o_DONE), 32'd0);
    check("rst_valid", 32'(o_VALID), 32'd0);
    check("rst_overflow", 32'(o_OVERFLOW), 32'd0);

    // Abort an in-flight conversion with reset at edge 10.
    convert(32'd123456, 1'b0);
    repeat (9) step();
    i_RESET = 1'b1;
    step();
    check("abort_busy", 32'(o_BUSY), 32'd0);
    check("abort_bcd", 32'(o_BCD), 32'd0);
    check("abort_done", 32'(o_DONE), 32'd0);
    i_RESET = 1'b0;
    dc = done_count;
    repeat (30) step();
    check("abort_no_done", 32'(done_count), 32'(dc));
    check("abort_valid", 32'(o_VALID), 32'd0);
    check("abort_bcd_hold", 32'(o_BCD), 32'd0);

    // Zero input.
    convert(32'd0, 1'b1);
    wait_done(c);
    check("zero_latency", 32'(c), 32'd21);
    check("zero_valid", 32'(o_VALID), 32'd1);
    step();

    // 123456 and busy length.
    convert(32'h0001E240, 1'b1);
    c = 0;
    while (o_BUSY && c < 100) begin
      step();
      c++;
    end
    check("busy_cycles", 32'(c), 32'd21);
    check("done_after_busy", 32'(o_DONE), 32'd1);
    step();
    check("done_one_cycle", 32'(o_DONE), 32'd0);

    convert(32'h000F423F, 1'b1);
    wait_done(c);
    step();
    convert(32'h000F4240, 1'b1);
    wait_done(c);
    step();

    // Request during a conversion is dropped; a request in the done cycle is taken.
    convert(32'd123456, 1'b1);
    repeat (4) step();
    i_BUS   = 32'd42;
    i_START = 1'b1;
    step();
    i_START = 1'b0;
    dc = done_count;
    wait_done(c);
    check("ignored_total_latency", 32'(c + 5), 32'd21);
    i_BUS   = 32'd42;
    i_START = 1'b1;
    exp_q.push_back(model(32'd42));
    wait_done(c);
    check("b2b_latency", 32'(c), 32'd22);
    i_START = 1'b0;
    check("single_done_for_ignored", 32'(done_count - dc), 32'd1);

    // Randomized conversions, frequently back to back.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: v = 32'($urandom_range(0, 99));
        1: v = 32'($urandom_range(0, 999999));
        2: v = 32'($urandom_range(1000000, 1048575));
        default: v = $urandom;
      endcase
      convert(v, 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end

    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      step();
      c++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
